hil_inverter: RTL and testbench

- Hardware-in-the-loop model of a three-phase two-level inverter.
- Measures the high-side gate duty of each phase over every PWM carrier period and converts it to an averaged phase voltage.
- Feeds the `v_a`/`v_b`/`v_c` inputs of the HIL motor model.
- Sits between the FOC controller's PWM outputs and the plant: the reader side of the PWM interface that the modulator writes.

---
 rtl/hil_inverter.sv | 145 ++++++++++++++
 tb/tb_hil_inverter.sv | 117 +++++++++++
 2 files changed

// File: rtl/hil_inverter.sv
// hil_inverter: measures per-phase PWM duty each carrier period and converts it to averaged phase voltages.
// Optional HIL_INV_CMR_EN: adds a CMR state that outputs star-point voltages with the common mode removed.
module hil_inverter #(
  parameter int N_BITS_VOLTAGE = 16,
  parameter int F_BITS_VOLTAGE = 8,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      pwm_sync,
  input  logic                      pwm_a,
  input  logic                      pwm_b,
  input  logic                      pwm_c,
  input  logic [N_BITS_VOLTAGE-1:0] vdc,
  output logic [N_BITS_VOLTAGE-1:0] v_a,
  output logic [N_BITS_VOLTAGE-1:0] v_b,
  output logic [N_BITS_VOLTAGE-1:0] v_c,
  output logic                      v_valid,
  output logic                      busy,
  output logic                      overrun
);
  localparam int N = N_BITS_VOLTAGE;
  localparam int F = F_BITS_VOLTAGE;
  localparam int C = CNT_WIDTH;
  localparam int SW = $clog2(F + 1);
  localparam logic signed [N+17:0] VMAX = {{19{1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [N+17:0] VMIN = ~VMAX;
  typedef enum logic [2:0] {
    IDLE,
    DIVIDE,
    SCALE,
`ifdef HIL_INV_CMR_EN
    CMR,
`endif
    OUTPUT
  } state_t;
  state_t state, nxt;
  logic [2:0] pwm, ge;
  logic [C-1:0] period_cnt, per_l;
  logic [C-1:0] high [3];
  logic [C:0] rem [3];
  logic [C:0] diff [3];
  logic [F:0] duty [3];
  logic [N+F:0] prod [3];
  logic signed [N+17:0] raw [3];
  logic [N-1:0] vdc_l;
  logic [N-1:0] vo [3];
  logic [SW-1:0] step;
  logic start;
  function automatic logic [N-1:0] sat(input logic signed [N+17:0] x);
    return x > VMAX ? VMAX[N-1:0] : x < VMIN ? VMIN[N-1:0] : x[N-1:0];
  endfunction
  assign pwm = {pwm_c, pwm_b, pwm_a};
  assign start = en && pwm_sync && state == IDLE && period_cnt >= C'(2);
  assign busy = state != IDLE && state != OUTPUT;
  assign v_valid = state == OUTPUT;
  assign v_a = vo[0];
  assign v_b = vo[1];
  assign v_c = vo[2];
  // one restoring-division step per cycle, quotient MSB first; scaled voltage from the finished quotient
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      ge[i] = rem[i] >= {1'b0, per_l};
      diff[i] = ge[i] ? rem[i] - {1'b0, per_l} : rem[i];
      prod[i] = (N+F+1)'(duty[i]) * (N+F+1)'(vdc_l);
      raw[i] = $signed({{17{1'b0}}, prod[i][N+F:F]}) - $signed({{19{1'b0}}, vdc_l[N-1:1]});
    end
  end
`ifdef HIL_INV_CMR_EN
  logic signed [N-1:0] ph [3];
  logic signed [N+17:0] s [3];
  logic signed [N+17:0] cm [3];
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      s[i] = ph[i] + ph[i] - ph[(i+1)%3] - ph[(i+2)%3];
      cm[i] = (s[i] * (N+18)'(21845) + (N+18)'(32768)) >>> 16;
    end
  end
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? DIVIDE : IDLE;
      DIVIDE:  nxt = step == SW'(F) ? SCALE : DIVIDE;
`ifdef HIL_INV_CMR_EN
      SCALE:   nxt = CMR;
      CMR:     nxt = OUTPUT;
`else
      SCALE:   nxt = OUTPUT;
`endif
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
      high <= '{default: '0};
      overrun <= 1'b0;
    end else if (en) begin
      period_cnt <= pwm_sync ? C'(1) : period_cnt + C'(!(&period_cnt));
      for (int i = 0; i < 3; i++)
        high[i] <= pwm_sync ? C'(pwm[i]) : high[i] + C'(pwm[i] && !(&high[i]));
      overrun <= overrun || (pwm_sync && state != IDLE) || (&period_cnt);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      per_l <= '0;
      vdc_l <= '0;
      step <= '0;
      rem <= '{default: '0};
      duty <= '{default: '0};
      vo <= '{default: '0};
`ifdef HIL_INV_CMR_EN
      ph <= '{default: '0};
`endif
    end else begin
      state <= nxt;
      if (start) begin
        per_l <= period_cnt;
        vdc_l <= vdc;
        step <= '0;
        for (int i = 0; i < 3; i++) rem[i] <= {1'b0, high[i]};
      end
      if (state == DIVIDE) begin
        step <= step + SW'(1);
        for (int i = 0; i < 3; i++) begin
          duty[i] <= {duty[i][F-1:0], ge[i]};
          rem[i] <= {diff[i][C-1:0], 1'b0};
        end
      end
`ifdef HIL_INV_CMR_EN
      if (state == SCALE)
        for (int i = 0; i < 3; i++) ph[i] <= sat(raw[i]);
      if (state == CMR)
        for (int i = 0; i < 3; i++) vo[i] <= sat(cm[i]);
`else
      if (state == SCALE)
        for (int i = 0; i < 3; i++) vo[i] <= sat(raw[i]);
`endif
    end
  end
endmodule

// File: tb/tb_hil_inverter.sv
// tb_hil_inverter: directed periods with a queue of expected conversions checked on every v_valid.
module tb_hil_inverter;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, pwm_sync = 1'b0;
  logic pwm_a = 1'b0, pwm_b = 1'b0, pwm_c = 1'b0;
  logic [15:0] vdc = 16'h1800;
  logic [15:0] v_a, v_b, v_c;
  logic v_valid, busy, overrun;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {logic [15:0] a, b, c; int t;} exp_t;
  exp_t q[$];
  exp_t pend;
  bit pend_conv = 0;
`ifdef HIL_INV_CMR_EN
  localparam int LAT = 12;
  localparam logic [15:0] P2A = 16'h0200, P2B = 16'hF600, P2C = 16'h0800;
`else
  localparam int LAT = 11;
  localparam logic [15:0] P2A = 16'h0600, P2B = 16'hFA00, P2C = 16'h0C00;
`endif
  hil_inverter dut (
    .clk(clk), .rst(rst), .en(en), .pwm_sync(pwm_sync),
    .pwm_a(pwm_a), .pwm_b(pwm_b), .pwm_c(pwm_c), .vdc(vdc),
    .v_a(v_a), .v_b(v_b), .v_c(v_c),
    .v_valid(v_valid), .busy(busy), .overrun(overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (v_valid) begin
      if (q.size() == 0) check("unexpected_v_valid", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("v_a", v_a, e.a);
        check("v_b", v_b, e.b);
        check("v_c", v_c, e.c);
        check("latency", cyc - e.t, LAT);
        check("busy_at_valid", busy, 0);
      end
    end
  end
  task automatic period(input int len, input int ha, input int hb, input int hc,
                        input int elo, input int ehi, input bit conv,
                        input logic [15:0] ea, input logic [15:0] eb, input logic [15:0] ec);
    if (pend_conv) begin
      pend.t = cyc;
      q.push_back(pend);
    end
    pend_conv = conv;
    pend.a = ea;
    pend.b = eb;
    pend.c = ec;
    for (int k = 0; k < len; k++) begin
      pwm_sync = k == 0;
      en = k < elo || k >= ehi;
      pwm_a = k < ha;
      pwm_b = k < hb;
      pwm_c = k < hc;
      @(posedge clk);
      #1;
    end
    pwm_sync = 1'b0;
    en = 1'b1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_v_a", v_a, 0);
    check("rst_v_b", v_b, 0);
    check("rst_v_c", v_c, 0);
    check("rst_v_valid", v_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    period(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    period(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("b2b_busy", busy, 0);
    check("b2b_overrun", overrun, 0);
    check("b2b_held_v_a", v_a, 0);
    period(100, 75, 25, 50, 0, 0, 1, 16'h0600, 16'hFA00, 16'h0000);
    period(100, 75, 25, 100, 0, 0, 1, P2A, P2B, P2C);
    period(100, 100, 0, 40, 50, 70, 1, 16'h0C00, 16'hF400, 16'h0000);
    period(100, 75, 25, 50, 0, 0, 1, 16'h0600, 16'hFA00, 16'h0000);
    check("no_overrun_yet", overrun, 0);
    period(5, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    period(100, 75, 25, 100, 0, 0, 1, P2A, P2B, P2C);
    check("overrun_set", overrun, 1);
    period(100, 75, 25, 100, 0, 0, 0, 0, 0, 0);
    period(4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("busy_in_divide", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_v_a", v_a, 0);
    check("midrst_v_b", v_b, 0);
    check("midrst_v_c", v_c, 0);
    check("midrst_v_valid", v_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_overrun", overrun, 0);
    period(100, 75, 25, 50, 0, 0, 1, 16'h0600, 16'hFA00, 16'h0000);
    period(100, 75, 25, 100, 0, 0, 0, 0, 0, 0);
    repeat (30) @(posedge clk);
    #1;
    check("all_conversions_seen", q.size(), 0);
    check("final_overrun", overrun, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
